// File: rtl/rs_sched_pkg.sv
// Shared types and constants for the reservation-station scheduler.
// FU class encodings, class slots and default sizing.
package rs_sched_pkg;

   localparam int RS_NUM_DEF   = 16;
   localparam int MULT_LAT_DEF = 4;
   localparam int RS_IDX_W     = $clog2(RS_NUM_DEF);
   localparam int FU_SEL_W     = 3;

   typedef enum logic [FU_SEL_W-1:0] {
      FU_SEL_NONE = 3'd0,
      FU_SEL_ALU  = 3'd1,
      FU_SEL_MULT = 3'd2,
      FU_SEL_MEM  = 3'd3,
      FU_SEL_BR   = 3'd4
   } fu_sel_e;

   localparam int CLS_N    = 4;
   localparam int CLS_ALU  = 0;
   localparam int CLS_MULT = 1;
   localparam int CLS_MEM  = 2;
   localparam int CLS_BR   = 3;

   function automatic int cnt_w(int lat);
      return (lat <= 2) ? 1 : $clog2(lat);
   endfunction

   function automatic fu_sel_e fu_sel_of(int c);
      unique case (c)
         CLS_ALU:  return FU_SEL_ALU;
         CLS_MULT: return FU_SEL_MULT;
         CLS_MEM:  return FU_SEL_MEM;
         default:  return FU_SEL_BR;
      endcase
   endfunction

endpackage

// File: rtl/rs_sched_rr_pick.sv
// Rotating-priority picker: first request at or after ptr,
// wrapping modulo N; N must be a power of two.
module rr_pick #(
   parameter int  N = 16,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         vld
);

   logic [W-1:0] j;

   // scan from ptr upward, take the first set request
   always_comb begin
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      j   = '0;
      for (int k = 0; k < N; k++) begin
         j = ptr + W'(k);
         if (!vld && req[j]) begin
            vld    = 1'b1;
            idx    = j;
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs_sched.sv
// RS allocator and per-class issue scheduler with multiplier busy tracking.
// Optional RS_SCHED_PERF_EN adds full/mult-blocked/issue perf counters.
module rs_sched
   import rs_sched_pkg::*;
#(
   parameter int  RS_NUM   = RS_NUM_DEF,
   parameter int  MULT_LAT = MULT_LAT_DEF,
   localparam int IDX_W    = $clog2(RS_NUM)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       disp_vld_i,
   input  logic [RS_NUM-1:0]          rs_avail_i,
   input  logic [RS_NUM-1:0]          rs_rdy_i,
   input  logic [RS_NUM*FU_SEL_W-1:0] rs_fu_sel_i,
   input  logic                       br_recovery_i,
   input  logic                       mult_squash_i,
   output logic [RS_NUM-1:0]          rs_load_o,
   output logic [RS_NUM-1:0]          rs_iss_en_o,
   output logic                       rs_full_o,
   output logic                       alu_iss_vld_o,
   output logic                       mult_iss_vld_o,
   output logic                       mem_iss_vld_o,
   output logic                       br_iss_vld_o,
   output logic [IDX_W-1:0]           alu_iss_idx_o,
   output logic [IDX_W-1:0]           mult_iss_idx_o,
   output logic [IDX_W-1:0]           mem_iss_idx_o,
   output logic [IDX_W-1:0]           br_iss_idx_o,
`ifdef RS_SCHED_PERF_EN
   output logic [31:0]                perf_full_cyc_o,
   output logic [31:0]                perf_mult_blk_o,
   output logic [31:0]                perf_iss_cnt_o,
`endif
   output logic                       mult_busy_o
);

   localparam int CNT_W = cnt_w(MULT_LAT);

   logic [CNT_W-1:0]  cnt;
   logic              busy;
   logic              iss_ok;
   logic [RS_NUM-1:0] a_gnt;
   logic [IDX_W-1:0]  a_idx;
   logic              a_vld;
   logic              full;
   logic              unused_a_idx;

   logic [RS_NUM-1:0] raw   [CLS_N];
   logic [RS_NUM-1:0] cand  [CLS_N];
   logic [IDX_W-1:0]  ptr   [CLS_N];
   logic [RS_NUM-1:0] gnt   [CLS_N];
   logic [IDX_W-1:0]  idx   [CLS_N];
   logic              vld   [CLS_N];
   logic              gv    [CLS_N];
   logic [FU_SEL_W-1:0] sel;

   assign busy   = (cnt != '0);
   assign iss_ok = rst_n & ~br_recovery_i;

   rr_pick #(.N(RS_NUM)) u_alloc (
      .req (rs_avail_i),
      .ptr ('0),
      .gnt (a_gnt),
      .idx (a_idx),
      .vld (a_vld)
   );

   assign unused_a_idx = ^a_idx;
   assign full         = ~a_vld;
   assign rs_full_o    = rst_n & full;
   assign rs_load_o    = (rst_n & disp_vld_i & ~full & ~br_recovery_i)
                         ? a_gnt : '0;
   assign mult_busy_o  = rst_n & busy;

   // per-class candidate masks; MULT is blocked while the unit is busy
   always_comb begin
      sel = '0;
      for (int c = 0; c < CLS_N; c++) begin
         raw[c] = '0;
      end
      for (int i = 0; i < RS_NUM; i++) begin
         sel = rs_fu_sel_i[i*FU_SEL_W +: FU_SEL_W];
         for (int c = 0; c < CLS_N; c++) begin
            raw[c][i] = rs_rdy_i[i] & ~rs_avail_i[i] &
                        (sel == fu_sel_of(c));
         end
      end
      for (int c = 0; c < CLS_N; c++) begin
         cand[c] = raw[c];
      end
      cand[CLS_MULT] = raw[CLS_MULT] & {RS_NUM{~busy}};
   end

   for (genvar c = 0; c < CLS_N; c++) begin : g_cls
      rr_pick #(.N(RS_NUM)) u_pick (
         .req (cand[c]),
         .ptr (ptr[c]),
         .gnt (gnt[c]),
         .idx (idx[c]),
         .vld (vld[c])
      );
      assign gv[c] = iss_ok & vld[c];
   end

   assign rs_iss_en_o = ({RS_NUM{gv[CLS_ALU]}}  & gnt[CLS_ALU])  |
                        ({RS_NUM{gv[CLS_MULT]}} & gnt[CLS_MULT]) |
                        ({RS_NUM{gv[CLS_MEM]}}  & gnt[CLS_MEM])  |
                        ({RS_NUM{gv[CLS_BR]}}   & gnt[CLS_BR]);

   assign alu_iss_vld_o  = gv[CLS_ALU];
   assign mult_iss_vld_o = gv[CLS_MULT];
   assign mem_iss_vld_o  = gv[CLS_MEM];
   assign br_iss_vld_o   = gv[CLS_BR];
   assign alu_iss_idx_o  = gv[CLS_ALU]  ? idx[CLS_ALU]  : '0;
   assign mult_iss_idx_o = gv[CLS_MULT] ? idx[CLS_MULT] : '0;
   assign mem_iss_idx_o  = gv[CLS_MEM]  ? idx[CLS_MEM]  : '0;
   assign br_iss_idx_o   = gv[CLS_BR]   ? idx[CLS_BR]   : '0;

   // advance each class pointer past its granted entry
   always_ff @(posedge clk) begin
      for (int c = 0; c < CLS_N; c++) begin
         if (!rst_n) begin
            ptr[c] <= '0;
         end else if (gv[c]) begin
            ptr[c] <= idx[c] + IDX_W'(1);
         end
      end
   end

   // multiplier occupancy window, cleared by squash
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (gv[CLS_MULT]) begin
         cnt <= CNT_W'(MULT_LAT - 1);
      end else if (mult_squash_i) begin
         cnt <= '0;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

`ifdef RS_SCHED_PERF_EN
   // free-running wrap-around event counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_full_cyc_o <= '0;
         perf_mult_blk_o <= '0;
         perf_iss_cnt_o  <= '0;
      end else begin
         if (full && disp_vld_i) begin
            perf_full_cyc_o <= perf_full_cyc_o + 32'd1;
         end
         if (busy && (|raw[CLS_MULT])) begin
            perf_mult_blk_o <= perf_mult_blk_o + 32'd1;
         end
         perf_iss_cnt_o <= perf_iss_cnt_o + 32'(gv[CLS_ALU]) +
                           32'(gv[CLS_MULT]) + 32'(gv[CLS_MEM]) +
                           32'(gv[CLS_BR]);
      end
   end
`endif

endmodule
